sseg_scan_ctrl: RTL and testbench

//   Scan controller for the N-digit multiplexed seven-segment display.

---
 rtl/sseg_scan_ctrl.sv | 115 +++++++++++
 tb/tb_sseg_scan_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with a double-buffered frame port,
// blanking interval, per-digit enable and PWM brightness.
module sseg_scan_ctrl #(
  parameter int N_DIG    = 4,
  parameter int PRESCALE = 4096,
  parameter int BLANK    = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [8*N_DIG-1:0] wr_data,
  input  logic [N_DIG-1:0]   dig_en,
  input  logic [3:0]         bright,
  output logic [N_DIG-1:0]   an,
  output logic [7:0]         sseg,
  output logic               frame_tick
);

  localparam int CW = $clog2(PRESCALE);
  localparam int DW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DW-1:0]      dig_q, dig_d;
  logic [8*N_DIG-1:0] disp_q, disp_d;
  logic [8*N_DIG-1:0] pbuf_q, pbuf_d;
  logic               pend_q, pend_d;
  logic [N_DIG-1:0]   an_q, an_d;
  logic [7:0]         sseg_q, sseg_d;
  logic               tick_q, tick_d;

  logic slot_end, frame_end, accept, lit;

  assign wr_ready   = ~pend_q;
  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = tick_q;

  assign slot_end  = (cnt_q == CW'(PRESCALE - 1));
  assign frame_end = slot_end && (dig_q == DW'(N_DIG - 1));
  assign accept    = wr_valid && ~pend_q;
  assign lit       = (state_q == S_DRIVE) && dig_en[dig_q]
                     && (cnt_q[3:0] <= bright);

  always_comb begin
    state_d = state_q;
    cnt_d   = slot_end ? '0 : cnt_q + CW'(1);
    dig_d   = dig_q;
    if (slot_end) begin
      dig_d = (dig_q == DW'(N_DIG - 1)) ? '0 : dig_q + DW'(1);
    end
    unique case (state_q)
      S_BLANK: if (cnt_q == CW'(BLANK - 1)) state_d = S_DRIVE;
      S_DRIVE: if (slot_end) state_d = S_BLANK;
      default: state_d = S_BLANK;
    endcase
  end

  // Commit looks at the pre-edge pending flag, so a frame accepted on
  // the frame-end cycle waits for the following boundary.
  always_comb begin
    disp_d = disp_q;
    pbuf_d = pbuf_q;
    pend_d = pend_q;
    if (frame_end && pend_q) begin
      disp_d = pbuf_q;
      pend_d = 1'b0;
    end
    if (accept) begin
      pbuf_d = wr_data;
      pend_d = 1'b1;
    end
  end

  always_comb begin
    an_d   = '1;
    sseg_d = 8'hFF;
    tick_d = frame_end;
    if (lit) begin
      an_d[dig_q] = 1'b0;
      sseg_d      = disp_q[{dig_q, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_BLANK;
      cnt_q   <= '0;
      dig_q   <= '0;
      disp_q  <= '1;
      pbuf_q  <= '1;
      pend_q  <= 1'b0;
      an_q    <= '1;
      sseg_q  <= 8'hFF;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      disp_q  <= disp_d;
      pbuf_q  <= pbuf_d;
      pend_q  <= pend_d;
      an_q    <= an_d;
      sseg_q  <= sseg_d;
      tick_q  <= tick_d;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: directed scenarios plus random traffic,
// all checked against a time-indexed reference model.
module tb_sseg_scan_ctrl;

  localparam int N   = 4;
  localparam int PRE = 32;
  localparam int BLK = 4;
  localparam int FRM = N * PRE;

  logic           clk;
  logic           reset;
  logic           wr_valid;
  logic           wr_ready;
  logic [8*N-1:0] wr_data;
  logic [N-1:0]   dig_en;
  logic [3:0]     bright;
  logic [N-1:0]   an;
  logic [7:0]     sseg;
  logic           frame_tick;

  sseg_scan_ctrl #(
    .N_DIG(N), .PRESCALE(PRE), .BLANK(BLK)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .dig_en(dig_en),
    .bright(bright), .an(an), .sseg(sseg),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // reference model: p = cycles since reset release
  int       p;
  logic [7:0] mdisp [N];
  logic [7:0] mpbuf [N];
  bit       mpend;
  bit       last_acc;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (p=%0d)", tag, obs, exp, p);
    end
  endtask

  task automatic model_reset();
    p = 0;
    mpend = 0;
    for (int k = 0; k < N; k++) begin
      mdisp[k] = 8'hFF;
      mpbuf[k] = 8'hFF;
    end
  endtask

  // one clock: starts and ends on a falling edge
  task automatic step();
    int slot, c;
    bit lit, tick, acc;
    logic [N-1:0] ea;
    logic [7:0] es;
    chk("wr_ready", wr_ready, !mpend);
    @(posedge clk);
    slot = (p / PRE) % N;
    c    = p % PRE;
    lit  = (c >= BLK) && dig_en[slot] && ((c % 16) <= int'(bright));
    tick = (p % FRM) == FRM - 1;
    ea = '1;
    es = 8'hFF;
    if (lit) begin
      ea[slot] = 1'b0;
      es = mdisp[slot];
    end
    acc = wr_valid && !mpend;
    if (tick && mpend) begin
      for (int k = 0; k < N; k++) mdisp[k] = mpbuf[k];
      mpend = 0;
    end
    if (acc) begin
      for (int k = 0; k < N; k++) mpbuf[k] = wr_data[8*k +: 8];
      mpend = 1;
    end
    last_acc = acc;
    p++;
    #1;
    chk("an", an, ea);
    chk("sseg", sseg, es);
    chk("frame_tick", frame_tick, tick);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // hold a frame on the port until accepted, bounded
  task automatic send(input logic [8*N-1:0] d);
    int guard;
    guard = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    last_acc = 0;
    while (!last_acc && guard < 3 * FRM) begin
      step();
      guard++;
    end
    if (!last_acc) chk("accept_timeout", 0, 1);
    wr_valid = 1'b0;
  endtask

  task automatic run_to(input int phase);
    int guard;
    guard = 0;
    while ((p % FRM) != phase && guard < 2 * FRM) begin
      step();
      guard++;
    end
    if (guard >= 2 * FRM) chk("phase_timeout", 0, 1);
  endtask

  int ticks, tick_gap, last_tick;

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b0;
    wr_valid = 1'b0;
    wr_data = '0;
    dig_en = 4'hF;
    bright = 4'd15;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_sseg", sseg, 8'hFF);
    chk("rst_tick", frame_tick, 1'b0);
    chk("rst_ready", wr_ready, 1'b1);
    reset = 1'b1;

    // blank display for a frame, tick spacing measured directly
    ticks = 0;
    last_tick = -1;
    for (int i = 0; i < 2 * FRM; i++) begin
      step();
      if (frame_tick) begin
        if (last_tick >= 0) chk("tick_period", p - last_tick, FRM);
        last_tick = p;
        ticks++;
      end
    end
    chk("tick_count", ticks, 2);

    // basic frame write, full brightness
    send(32'hC0F9A4B0);
    run_to(0);
    run(PRE);
    chk("slot0_sseg", sseg, 8'hB0);
    chk("slot0_an", an, 4'b1110);
    run(FRM);

    // PWM duty and dark digit
    bright = 4'd3;
    run(FRM);
    dig_en = 4'b1011;
    bright = 4'd15;
    run(FRM);
    dig_en = 4'hF;

    // back-to-back frames: B stalls until after commit of A
    send(32'h11223344);
    send(32'h55667788);
    run(3 * FRM);

    // reset in S_DRIVE with a frame pending
    run_to(PRE + 10);
    send(32'h00000000);
    run_to(2 * PRE + 12);
    chk("pre_rst_pend", wr_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("async_an", an, 4'hF);
    chk("async_sseg", sseg, 8'hFF);
    chk("async_ready", wr_ready, 1'b1);
    @(negedge clk);
    model_reset();
    reset = 1'b1;
    run(2 * FRM);

    // random traffic
    for (int i = 0; i < 10 * FRM; i++) begin
      wr_valid = ($urandom_range(0, 40) == 0);
      wr_data  = $urandom;
      if ($urandom_range(0, 63) == 0) dig_en = 4'($urandom);
      if ($urandom_range(0, 31) == 0) bright = 4'($urandom);
      step();
    end
    wr_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
